// File: rtl/serial_add.sv
// serial_add: digit-serial unsigned adder, DIGITWIDTH bits per clock, start/done handshake.
//   Clk   : rising-edge clock
//   Rst_n : asynchronous active-low reset
//   start : request, honoured only when not busy (IDLE or DONE)
//   a, b  : operands, captured on the accepting edge
//   busy  : high while digits are being added
//   done  : one-cycle pulse when sum/cout are updated
//   sum   : (a + b) mod 2^DATAWIDTH, held until the next completion
//   cout  : carry out of the MSB, held with sum
module serial_add #(
    parameter int DATAWIDTH  = 8,
    parameter int DIGITWIDTH = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 cout
);
    localparam int N  = DATAWIDTH / DIGITWIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [DATAWIDTH-1:0] a_sh, b_sh, res, res_nx;
    logic [DIGITWIDTH:0] dig;
    logic [CW-1:0] cnt;
    logic carry, accept, last;
    assign accept = start && (state != RUN);
    assign last   = cnt == CW'(N - 1);
    assign dig    = {1'b0, a_sh[DIGITWIDTH-1:0]} + {1'b0, b_sh[DIGITWIDTH-1:0]}
                  + {{DIGITWIDTH{1'b0}}, carry};
    // New digit enters at the MSB end; after N digits the LSB digit has reached bit 0.
    assign res_nx = DATAWIDTH'({dig[DIGITWIDTH-1:0], res} >> DIGITWIDTH);
    assign busy   = state == RUN;
    assign done   = state == DONE;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGITWIDTH;
            b_sh  <= b_sh >> DIGITWIDTH;
            carry <= dig[DIGITWIDTH];
            cnt   <= cnt + CW'(1);
            res   <= res_nx;
            if (last) begin
                sum  <= res_nx;
                cout <= dig[DIGITWIDTH];
            end
        end
    end
endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: randomized self-checking bench for serial_add against an arithmetic reference.
module tb_serial_add;
    localparam int W = 8, D = 2, N = W / D;
    logic clk = 0, rst_n = 0, start = 0, start8 = 0;
    logic [W-1:0] a = 0, b = 0, a8 = 0, b8 = 0;
    logic busy, done, cout, busy8, done8, cout8;
    logic [W-1:0] sum, sum8;
    int n_chk = 0, n_pass = 0;
    logic [W-1:0] opa [40];
    logic [W-1:0] opb [40];

    always #5 clk = ~clk;

    serial_add #(.DATAWIDTH(W), .DIGITWIDTH(D)) dut (
        .Clk(clk), .Rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout));

    serial_add #(.DATAWIDTH(W), .DIGITWIDTH(W)) dut8 (
        .Clk(clk), .Rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [W:0] r;
        r = ref_add(x, y);
        a = x;
        b = y;
        start = 1;
        step();
        start = 0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < N; i++) begin
            check({tag, " busy"}, 32'(busy), 1);
            check({tag, " early_done"}, 32'(done), 0);
            step();
        end
        check({tag, " done"}, 32'(done), 1);
        check({tag, " busy_end"}, 32'(busy), 0);
        check({tag, " sum"}, 32'(sum), 32'(r[W-1:0]));
        check({tag, " cout"}, 32'(cout), 32'(r[W]));
        step();
        check({tag, " done_pulse"}, 32'(done), 0);
        check({tag, " sum_hold"}, 32'(sum), 32'(r[W-1:0]));
    endtask

    initial begin
        int dcnt;
        logic [W:0] r;
        repeat (2) step();
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst sum", 32'(sum), 0);
        check("rst cout", 32'(cout), 0);
        rst_n = 1;
        dcnt = 0;
        repeat (20) begin
            step();
            dcnt += int'(done);
        end
        check("idle no_done", 32'(dcnt), 0);

        run_op(8'd10, 8'd5, "basic");
        run_op(8'd5, 8'd5, "sub_inv1");
        run_op(8'd251, 8'd10, "sub_inv2");
        run_op(8'd255, 8'd1, "wrap1");
        run_op(8'd255, 8'd255, "wrap2");
        run_op(8'd0, 8'd0, "zero");
        repeat (20) run_op(W'($urandom), W'($urandom), "rand");

        // start held high: accepts every N+1 edges, operands at other edges ignored
        for (int t = 0; t < 40; t++) begin
            a = W'($urandom);
            b = W'($urandom);
            start = 1;
            opa[t] = a;
            opb[t] = b;
            step();
            check("bb done", 32'(done), 32'(t % (N + 1) == N));
            check("bb busy", 32'(busy), 32'(t % (N + 1) != N));
            if (t % (N + 1) == N) begin
                r = ref_add(opa[t-N], opb[t-N]);
                check("bb sum", 32'(sum), 32'(r[W-1:0]));
                check("bb cout", 32'(cout), 32'(r[W]));
            end
        end
        start = 0;
        step();
        check("bb idle", 32'(busy | done), 0);

        // asynchronous reset during the second RUN cycle
        run_op(8'd200, 8'd100, "pre_rst");
        a = 8'd1;
        b = 8'd2;
        start = 1;
        step();
        start = 0;
        step();
        rst_n = 0;
        #1;
        check("arst busy", 32'(busy), 0);
        check("arst done", 32'(done), 0);
        check("arst sum", 32'(sum), 0);
        check("arst cout", 32'(cout), 0);
        step();
        rst_n = 1;
        dcnt = 0;
        repeat (N + 2) begin
            step();
            dcnt += int'(done);
        end
        check("arst no_done", 32'(dcnt), 0);
        run_op(8'd100, 8'd27, "post_rst");

        // full-width digit: one RUN cycle
        a8 = 8'd10;
        b8 = 8'd5;
        start8 = 1;
        step();
        start8 = 0;
        check("w8 busy", 32'(busy8), 1);
        check("w8 early_done", 32'(done8), 0);
        step();
        check("w8 done", 32'(done8), 1);
        check("w8 sum", 32'(sum8), 15);
        check("w8 cout", 32'(cout8), 0);
        step();
        check("w8 done_pulse", 32'(done8), 0);
        repeat (8) begin
            a8 = W'($urandom);
            b8 = W'($urandom);
            r = ref_add(a8, b8);
            start8 = 1;
            step();
            start8 = 0;
            a8 = W'($urandom);
            b8 = W'($urandom);
            step();
            check("w8r done", 32'(done8), 1);
            check("w8r sum", 32'(sum8), 32'(r[W-1:0]));
            check("w8r cout", 32'(cout8), 32'(r[W]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
